// File: rtl/mycpu_pkg.sv
// -----------------------------------------------------------------------------
// mycpu_pkg -- shared CPU definitions.
//
// Holds the operation enumeration (op_t), the instruction word type (word_t)
// and the MIPS32 field constants (primary opcodes, SPECIAL funct codes,
// REGIMM rt codes, COP0 rs codes). Decode-side logic reuses the same
// constants, so the encoder and decoder cannot disagree on field values.
// Small helpers assemble the common R/I/COP0 word layouts.
// -----------------------------------------------------------------------------
package mycpu_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [5:0] {
    OP_NOP,
    OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
    OP_JR, OP_JALR, OP_SYSCALL, OP_BREAK,
    OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU,
    OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL,
    OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
    OP_J, OP_JAL,
    OP_MFC0, OP_MTC0, OP_ERET,
    OP_DECODE_ERROR
  } op_t;

  // Primary opcodes
  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_REGIMM  = 6'b000001;
  localparam logic [5:0] OPC_J       = 6'b000010;
  localparam logic [5:0] OPC_JAL     = 6'b000011;
  localparam logic [5:0] OPC_BEQ     = 6'b000100;
  localparam logic [5:0] OPC_BNE     = 6'b000101;
  localparam logic [5:0] OPC_BLEZ    = 6'b000110;
  localparam logic [5:0] OPC_BGTZ    = 6'b000111;
  localparam logic [5:0] OPC_ADDI    = 6'b001000;
  localparam logic [5:0] OPC_ADDIU   = 6'b001001;
  localparam logic [5:0] OPC_SLTI    = 6'b001010;
  localparam logic [5:0] OPC_SLTIU   = 6'b001011;
  localparam logic [5:0] OPC_ANDI    = 6'b001100;
  localparam logic [5:0] OPC_ORI     = 6'b001101;
  localparam logic [5:0] OPC_XORI    = 6'b001110;
  localparam logic [5:0] OPC_LUI     = 6'b001111;
  localparam logic [5:0] OPC_COP0    = 6'b010000;
  localparam logic [5:0] OPC_LB      = 6'b100000;
  localparam logic [5:0] OPC_LH      = 6'b100001;
  localparam logic [5:0] OPC_LW      = 6'b100011;
  localparam logic [5:0] OPC_LBU     = 6'b100100;
  localparam logic [5:0] OPC_LHU     = 6'b100101;
  localparam logic [5:0] OPC_SB      = 6'b101000;
  localparam logic [5:0] OPC_SH      = 6'b101001;
  localparam logic [5:0] OPC_SW      = 6'b101011;

  // SPECIAL funct codes
  localparam logic [5:0] FUNCT_SLL     = 6'b000000;
  localparam logic [5:0] FUNCT_SRL     = 6'b000010;
  localparam logic [5:0] FUNCT_SRA     = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV    = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV    = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV    = 6'b000111;
  localparam logic [5:0] FUNCT_JR      = 6'b001000;
  localparam logic [5:0] FUNCT_JALR    = 6'b001001;
  localparam logic [5:0] FUNCT_SYSCALL = 6'b001100;
  localparam logic [5:0] FUNCT_BREAK   = 6'b001101;
  localparam logic [5:0] FUNCT_MFHI    = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI    = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO    = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO    = 6'b010011;
  localparam logic [5:0] FUNCT_MULT    = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU   = 6'b011001;
  localparam logic [5:0] FUNCT_DIV     = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU    = 6'b011011;
  localparam logic [5:0] FUNCT_ADD     = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU    = 6'b100001;
  localparam logic [5:0] FUNCT_SUB     = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU    = 6'b100011;
  localparam logic [5:0] FUNCT_AND     = 6'b100100;
  localparam logic [5:0] FUNCT_OR      = 6'b100101;
  localparam logic [5:0] FUNCT_XOR     = 6'b100110;
  localparam logic [5:0] FUNCT_NOR     = 6'b100111;
  localparam logic [5:0] FUNCT_SLT     = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU    = 6'b101011;

  // REGIMM rt codes
  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  // COP0 rs codes
  localparam logic [4:0] COP0_RS_MF = 5'b00000;
  localparam logic [4:0] COP0_RS_MT = 5'b00100;

  // ERET is a fixed word: COP0, CO bit set, funct 011000
  localparam word_t WORD_ERET = {OPC_COP0, 1'b1, 19'b0, 6'b011000};

  function automatic word_t mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [4:0] sa,
                                 input logic [5:0] funct);
    return {OPC_SPECIAL, rs, rt, rd, sa, funct};
  endfunction

  function automatic word_t mk_i(input logic [5:0] opc, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic word_t mk_cop0(input logic [4:0] rs_code,
                                    input logic [4:0] rt, input logic [4:0] rd);
    return {OPC_COP0, rs_code, rt, rd, 11'b0};
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// -----------------------------------------------------------------------------
// instr_field_pack -- purely combinational MIPS32 field encoder.
//
// Ports:
//   op     in  op_t      operation to encode
//   rs/rt/rd/shamt in 5  register and shift fields
//   imm    in  16        immediate / branch offset
//   target in  26        jump target
//   instr  out word_t    encoded word (fields an op does not use are zero)
//   err    out 1         op has no encoding; instr is then zero
// -----------------------------------------------------------------------------
module instr_field_pack
  import mycpu_pkg::*;
(
  input  op_t         op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output word_t       instr,
  output logic        err
);

  localparam logic [4:0] Z5 = 5'd0;

  always_comb begin
    instr = '0;
    err   = 1'b0;
    case (op)
      OP_NOP:     instr = '0;
      // Constant shifts take the amount from shamt; rs is not a source.
      OP_SLL:     instr = mk_r(Z5, rt, rd, shamt, FUNCT_SLL);
      OP_SRL:     instr = mk_r(Z5, rt, rd, shamt, FUNCT_SRL);
      OP_SRA:     instr = mk_r(Z5, rt, rd, shamt, FUNCT_SRA);
      OP_SLLV:    instr = mk_r(rs, rt, rd, Z5, FUNCT_SLLV);
      OP_SRLV:    instr = mk_r(rs, rt, rd, Z5, FUNCT_SRLV);
      OP_SRAV:    instr = mk_r(rs, rt, rd, Z5, FUNCT_SRAV);
      OP_JR:      instr = mk_r(rs, Z5, Z5, Z5, FUNCT_JR);
      OP_JALR:    instr = mk_r(rs, Z5, rd, Z5, FUNCT_JALR);
      // The 20-bit code field of SYSCALL/BREAK is always emitted as zero.
      OP_SYSCALL: instr = mk_r(Z5, Z5, Z5, Z5, FUNCT_SYSCALL);
      OP_BREAK:   instr = mk_r(Z5, Z5, Z5, Z5, FUNCT_BREAK);
      OP_MFHI:    instr = mk_r(Z5, Z5, rd, Z5, FUNCT_MFHI);
      OP_MTHI:    instr = mk_r(rs, Z5, Z5, Z5, FUNCT_MTHI);
      OP_MFLO:    instr = mk_r(Z5, Z5, rd, Z5, FUNCT_MFLO);
      OP_MTLO:    instr = mk_r(rs, Z5, Z5, Z5, FUNCT_MTLO);
      OP_MULT:    instr = mk_r(rs, rt, Z5, Z5, FUNCT_MULT);
      OP_MULTU:   instr = mk_r(rs, rt, Z5, Z5, FUNCT_MULTU);
      OP_DIV:     instr = mk_r(rs, rt, Z5, Z5, FUNCT_DIV);
      OP_DIVU:    instr = mk_r(rs, rt, Z5, Z5, FUNCT_DIVU);
      OP_ADD:     instr = mk_r(rs, rt, rd, Z5, FUNCT_ADD);
      OP_ADDU:    instr = mk_r(rs, rt, rd, Z5, FUNCT_ADDU);
      OP_SUB:     instr = mk_r(rs, rt, rd, Z5, FUNCT_SUB);
      OP_SUBU:    instr = mk_r(rs, rt, rd, Z5, FUNCT_SUBU);
      OP_AND:     instr = mk_r(rs, rt, rd, Z5, FUNCT_AND);
      OP_OR:      instr = mk_r(rs, rt, rd, Z5, FUNCT_OR);
      OP_XOR:     instr = mk_r(rs, rt, rd, Z5, FUNCT_XOR);
      OP_NOR:     instr = mk_r(rs, rt, rd, Z5, FUNCT_NOR);
      OP_SLT:     instr = mk_r(rs, rt, rd, Z5, FUNCT_SLT);
      OP_SLTU:    instr = mk_r(rs, rt, rd, Z5, FUNCT_SLTU);
      // REGIMM: the rt slot carries the branch kind, caller's rt is dropped.
      OP_BLTZ:    instr = mk_i(OPC_REGIMM, rs, RT_BLTZ, imm);
      OP_BGEZ:    instr = mk_i(OPC_REGIMM, rs, RT_BGEZ, imm);
      OP_BLTZAL:  instr = mk_i(OPC_REGIMM, rs, RT_BLTZAL, imm);
      OP_BGEZAL:  instr = mk_i(OPC_REGIMM, rs, RT_BGEZAL, imm);
      OP_BEQ:     instr = mk_i(OPC_BEQ, rs, rt, imm);
      OP_BNE:     instr = mk_i(OPC_BNE, rs, rt, imm);
      // BLEZ/BGTZ compare rs against zero; rt must be zero.
      OP_BLEZ:    instr = mk_i(OPC_BLEZ, rs, Z5, imm);
      OP_BGTZ:    instr = mk_i(OPC_BGTZ, rs, Z5, imm);
      OP_ADDI:    instr = mk_i(OPC_ADDI, rs, rt, imm);
      OP_ADDIU:   instr = mk_i(OPC_ADDIU, rs, rt, imm);
      OP_SLTI:    instr = mk_i(OPC_SLTI, rs, rt, imm);
      OP_SLTIU:   instr = mk_i(OPC_SLTIU, rs, rt, imm);
      OP_ANDI:    instr = mk_i(OPC_ANDI, rs, rt, imm);
      OP_ORI:     instr = mk_i(OPC_ORI, rs, rt, imm);
      OP_XORI:    instr = mk_i(OPC_XORI, rs, rt, imm);
      OP_LUI:     instr = mk_i(OPC_LUI, Z5, rt, imm);
      OP_LB:      instr = mk_i(OPC_LB, rs, rt, imm);
      OP_LH:      instr = mk_i(OPC_LH, rs, rt, imm);
      OP_LW:      instr = mk_i(OPC_LW, rs, rt, imm);
      OP_LBU:     instr = mk_i(OPC_LBU, rs, rt, imm);
      OP_LHU:     instr = mk_i(OPC_LHU, rs, rt, imm);
      OP_SB:      instr = mk_i(OPC_SB, rs, rt, imm);
      OP_SH:      instr = mk_i(OPC_SH, rs, rt, imm);
      OP_SW:      instr = mk_i(OPC_SW, rs, rt, imm);
      OP_J:       instr = {OPC_J, target};
      OP_JAL:     instr = {OPC_JAL, target};
      OP_MFC0:    instr = mk_cop0(COP0_RS_MF, rt, rd);
      OP_MTC0:    instr = mk_cop0(COP0_RS_MT, rt, rd);
      OP_ERET:    instr = WORD_ERET;
      // DECODE_ERROR and any out-of-range op value
      default: begin
        instr = '0;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder -- MIPS32 instruction encoder with valid/ready handshakes.
//
// The field encoding lives in instr_field_pack; this module only carries the
// encoded word through a 2-entry skid buffer (output register + skid register)
// so in_ready is a flop and never depends combinationally on out_ready.
//
// Ports:
//   clk, resetn (async, active-low)
//   in_valid/in_ready, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target
//   out_valid/out_ready, out_instr, out_err
//   err_count [15:0]  only when INSTR_ENCODER_ERRCNT_EN is defined: saturating
//                     count of output handshakes that carried out_err=1
// -----------------------------------------------------------------------------
module instr_encoder
  import mycpu_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  op_t         in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output word_t       out_instr,
  output logic        out_err
`ifdef INSTR_ENCODER_ERRCNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  word_t pack_instr;
  logic  pack_err;

  instr_field_pack u_pack (
    .op     (in_op),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .shamt  (in_shamt),
    .imm    (in_imm),
    .target (in_target),
    .instr  (pack_instr),
    .err    (pack_err)
  );

  logic  out_valid_q, out_valid_d;
  word_t out_instr_q, out_instr_d;
  logic  out_err_q,   out_err_d;
  logic  skid_valid_q, skid_valid_d;
  word_t skid_instr_q, skid_instr_d;
  logic  skid_err_q,   skid_err_d;
  logic  in_ready_q,   in_ready_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_err_d   = skid_err_q;

    if (!out_valid_q || out_fire) begin
      // Output slot frees up: the skid entry is older than any new input,
      // and in_fire cannot coincide with a full skid, so order is kept.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_instr_d  = skid_instr_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_valid_d = 1'b1;
        out_instr_d = pack_instr;
        out_err_d   = pack_err;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      // Output stalled: park the new word in the skid register.
      skid_valid_d = 1'b1;
      skid_instr_d = pack_instr;
      skid_err_d   = pack_err;
    end

    in_ready_d = ~skid_valid_d;
  end

  // --- output + skid register stage ---
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_err_q   <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_err_q   <= skid_err_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;

`ifdef INSTR_ENCODER_ERRCNT_EN
  logic [15:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (out_fire && out_err_q && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  import mycpu_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  op_t         in_op;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_valid;
  logic        out_ready;
  word_t       out_instr;
  logic        out_err;
`ifdef INSTR_ENCODER_ERRCNT_EN
  logic [15:0] err_count;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  instr_encoder dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_shamt  (in_shamt),
    .in_imm    (in_imm),
    .in_target (in_target),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err)
`ifdef INSTR_ENCODER_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    op_t         op;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input op_t op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sa,
                         input logic [15:0] imm, input logic [25:0] tgt);
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sa;
    in_imm = imm; in_target = tgt;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_req(OP_NOP, 0, 0, 0, 0, 0, 0);
    repeat (2) step();
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0 || out_err !== 1'b0)
      $display("FAIL reset_state: got v=%b rdy=%b instr=%h err=%b, expected v=0 rdy=1 instr=0 err=0",
               out_valid, in_ready, out_instr, out_err);
    else pass_cnt++;
    @(negedge clk); resetn = 1'b1;
    step();
  endtask

  task automatic test_addiu();
    out_ready = 1'b1;
    set_req(OP_ADDIU, 5'd29, 5'd29, 5'd0, 5'd0, 16'hFFF8, 26'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || out_instr !== 32'h27BDFFF8 || out_err !== 1'b0)
      $display("FAIL addiu: got v=%b instr=%h err=%b, expected v=1 instr=27bdfff8 err=0",
               out_valid, out_instr, out_err);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b0)
      $display("FAIL addiu_drain: got v=%b, expected v=0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_decode_error();
    out_ready = 1'b1;
    set_req(OP_DECODE_ERROR, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 16'hFFFF, 26'h3FFFFFF);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || out_instr !== 32'h0 || out_err !== 1'b1)
      $display("FAIL decode_error: got v=%b instr=%h err=%b, expected v=1 instr=0 err=1",
               out_valid, out_instr, out_err);
    else pass_cnt++;
`ifdef INSTR_ENCODER_ERRCNT_EN
    total_cnt++;
    if (err_count !== 16'd0) $display("FAIL err_count_before: got %0d expected 0", err_count);
    else pass_cnt++;
`endif
    step();
`ifdef INSTR_ENCODER_ERRCNT_EN
    total_cnt++;
    if (err_count !== 16'd1) $display("FAIL err_count_after: got %0d expected 1", err_count);
    else pass_cnt++;
`endif
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL decode_error_drain: got v=%b expected 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_sll_garbage();
    out_ready = 1'b1;
    set_req(OP_SLL, 5'h1F, 5'd2, 5'd3, 5'd4, 16'hABCD, 26'h2AAAAAA);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || out_instr !== 32'h00021900 || out_err !== 1'b0)
      $display("FAIL sll_zero_fields: got v=%b instr=%h err=%b, expected v=1 instr=00021900 err=0",
               out_valid, out_instr, out_err);
    else pass_cnt++;
    step();
  endtask

  task automatic test_encodings();
    vec_t v[13];
    v[0]  = '{OP_ADD,     5'd1,  5'd2,  5'd3,  5'h1F, 16'hFFFF, 26'h1,       32'h00221820};
    v[1]  = '{OP_BLTZAL,  5'd4,  5'd7,  5'd9,  5'd9,  16'h0010, 26'h1,       32'h04900010};
    v[2]  = '{OP_MFC0,    5'h1F, 5'd8,  5'd12, 5'd3,  16'h5555, 26'h1,       32'h40086000};
    v[3]  = '{OP_MTC0,    5'h1F, 5'd8,  5'd12, 5'd3,  16'h5555, 26'h1,       32'h40886000};
    v[4]  = '{OP_NOP,     5'd9,  5'd9,  5'd9,  5'd9,  16'h9999, 26'h99,      32'h00000000};
    v[5]  = '{OP_LUI,     5'h1F, 5'd1,  5'd6,  5'd6,  16'h1234, 26'h1,       32'h3C011234};
    v[6]  = '{OP_SYSCALL, 5'd5,  5'd6,  5'd7,  5'd8,  16'hFFFF, 26'h3FFFFFF, 32'h0000000C};
    v[7]  = '{OP_JR,      5'd31, 5'd5,  5'd6,  5'd7,  16'h1111, 26'h1,       32'h03E00008};
    v[8]  = '{OP_SW,      5'd29, 5'd31, 5'd3,  5'd3,  16'h0004, 26'h1,       32'hAFBF0004};
    v[9]  = '{OP_JAL,     5'd3,  5'd3,  5'd3,  5'd3,  16'h3333, 26'h3FFFFFF, 32'h0FFFFFFF};
    v[10] = '{OP_BLEZ,    5'd2,  5'd5,  5'd5,  5'd5,  16'hFFFF, 26'h1,       32'h1840FFFF};
    v[11] = '{OP_MULT,    5'd3,  5'd4,  5'd9,  5'd9,  16'h7777, 26'h1,       32'h00640018};
    v[12] = '{OP_MFHI,    5'd1,  5'd1,  5'd7,  5'd1,  16'h7777, 26'h1,       32'h00003810};
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      set_req(v[i].op, v[i].rs, v[i].rt, v[i].rd, v[i].sa, v[i].imm, v[i].tgt);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      total_cnt++;
      if (out_valid !== 1'b1 || out_instr !== v[i].exp || out_err !== 1'b0)
        $display("FAIL encode_%s: got v=%b instr=%h err=%b, expected v=1 instr=%h err=0",
                 v[i].op.name(), out_valid, out_instr, out_err, v[i].exp);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    set_req(OP_ERET, 5'd7, 5'd7, 5'd7, 5'd7, 16'h7777, 26'h1);
    in_valid = 1'b1;
    step();
    set_req(OP_J, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h0100000);
    total_cnt++;
    if (out_valid !== 1'b1 || out_instr !== 32'h42000018 || in_ready !== 1'b1)
      $display("FAIL b2b_eret: got v=%b instr=%h rdy=%b, expected v=1 instr=42000018 rdy=1",
               out_valid, out_instr, in_ready);
    else pass_cnt++;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || out_instr !== 32'h08100000)
      $display("FAIL b2b_j: got v=%b instr=%h, expected v=1 instr=08100000", out_valid, out_instr);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL b2b_drain: got v=%b expected 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    set_req(OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);        // 00221820
    in_valid = 1'b1;
    step();
    total_cnt++;
    if (in_ready !== 1'b1 || out_instr !== 32'h00221820)
      $display("FAIL stall_first: got rdy=%b instr=%h, expected rdy=1 instr=00221820",
               in_ready, out_instr);
    else pass_cnt++;
    set_req(OP_SW, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0004, 26'h0);    // afbf0004
    step();
    total_cnt++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== 32'h00221820)
      $display("FAIL stall_full: got rdy=%b v=%b instr=%h, expected rdy=0 v=1 instr=00221820",
               in_ready, out_valid, out_instr);
    else pass_cnt++;
    set_req(OP_LUI, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1234, 26'h0);     // 3c011234
    repeat (2) step();
    total_cnt++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== 32'h00221820 || out_err !== 1'b0)
      $display("FAIL stall_hold: got rdy=%b v=%b instr=%h err=%b, expected rdy=0 v=1 instr=00221820 err=0",
               in_ready, out_valid, out_instr, out_err);
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    total_cnt++;
    if (out_valid !== 1'b1 || out_instr !== 32'hAFBF0004 || in_ready !== 1'b1)
      $display("FAIL stall_drain2: got v=%b instr=%h rdy=%b, expected v=1 instr=afbf0004 rdy=1",
               out_valid, out_instr, in_ready);
    else pass_cnt++;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || out_instr !== 32'h3C011234)
      $display("FAIL stall_third: got v=%b instr=%h, expected v=1 instr=3c011234", out_valid, out_instr);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL stall_end: got v=%b expected 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic seen;
    out_ready = 1'b0;
    set_req(OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    in_valid = 1'b1;
    step();
    set_req(OP_DECODE_ERROR, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL rstmid_full: got rdy=%b v=%b, expected rdy=0 v=1", in_ready, out_valid);
    else pass_cnt++;
    #2 resetn = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0 || out_err !== 1'b0)
      $display("FAIL rstmid_async: got v=%b rdy=%b instr=%h err=%b, expected v=0 rdy=1 instr=0 err=0",
               out_valid, in_ready, out_instr, out_err);
    else pass_cnt++;
    @(posedge clk);
    #3 resetn = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      step();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL rstmid_stale: got stale word after reset, expected none");
    else pass_cnt++;
`ifdef INSTR_ENCODER_ERRCNT_EN
    total_cnt++;
    if (err_count !== 16'd0) $display("FAIL rstmid_errcnt: got %0d expected 0", err_count);
    else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_decode_error();
    test_addiu();
    test_sll_garbage();
    test_encodings();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port in_valid  input  1  request valid.
REQ-004 SHALL have port in_ready  output  1  encoder can accept a request this cycle.
REQ-005 SHALL have port in_op  input  op_t  operation to encode.
REQ-006 SHALL have port in_rs, in_rt, in_rd, in_shamt  input  5 each  register and shift fields.
REQ-007 SHALL have port in_imm  input  16  immediate or branch offset.
REQ-008 SHALL have port in_target  input  26  jump target field.
REQ-009 SHALL have port out_valid  output  1  encoded word valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the word.
REQ-011 SHALL have port out_instr  output  word_t  encoded MIPS32 instruction.
REQ-012 SHALL have port out_err  output  1  word is invalid: op has no encoding.

Function
REQ-013 SHALL encode R-type ops as opcode 000000 with rs, rt, rd, shamt and funct; funct values are SLL 000000, SRL 000010, SRA 000011, SLLV 000100, SRLV 000110, SRAV 000111, JR 001000, JALR 001001, SYSCALL 001100, BREAK 001101, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, ADD 100000, ADDU 100001, SUB 100010, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLTU 101011.
REQ-014 SHALL encode REGIMM ops as opcode 000001 with rt field BLTZ 00000, BGEZ 00001, BLTZAL 10000, BGEZAL 10001, rs and imm; in_rt is ignored.
REQ-015 SHALL encode I-type ops as {opcode, rs, rt, imm} with these opcodes:
- BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111
- ADDI 001000, ADDIU 001001, SLTI 001010, SLTIU 001011, ANDI 001100, ORI 001101, XORI 001110, LUI 001111
- LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011
REQ-016 SHALL encode J as {000010, target} and JAL as {000011, target}.
REQ-017 SHALL encode MFC0 as {010000, 00000, rt, rd, 11'b0}, MTC0 as {010000, 00100, rt, rd, 11'b0}, and ERET as 32'h42000018.
REQ-018 SHALL encode NOP as 32'h00000000.
REQ-019 SHALL force to zero every field that is unused by an op (for example rs/rt/rd of SYSCALL, or shamt of ADD).
REQ-020 SHALL, for DECODE_ERROR or any unlisted op, output out_instr=0 with out_err=1; the word is still transferred through the handshake.
REQ-021 SHALL have a latency of exactly 1 cycle from input handshake to out_valid when the output side is unstalled.
REQ-022 SHALL sustain a throughput of 1 word/cycle while out_ready is held high.
REQ-023 SHALL buffer through a 2-entry skid: output register plus one skid register.
- in_ready = skid register empty.
- in_ready SHALL be registered, with no combinational path from out_ready.
REQ-024 SHALL hold out_valid, out_instr and out_err stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, when an input and an output handshake occur in the same cycle, keep order strictly FIFO, with no loss and no duplication.
REQ-026 SHALL accept no input while the skid register is full; in that state in_valid is ignored.

Reset
REQ-027 SHALL, on resetn=0 at any time including mid-transfer, immediately clear both entries; out_valid=0, out_instr=0, out_err=0, in_ready=1 after reset.
REQ-028 SHALL not emit any word accepted before reset after reset is released.

Configuration
REQ-029 SHALL, when INSTR_ENCODER_ERRCNT_EN is defined, add output err_count (16-bit). err_count increments on each output handshake with out_err=1, saturates at 16'hFFFF, and resets to 0.
REQ-030 SHALL, when INSTR_ENCODER_ERRCNT_EN is undefined, have no err_count port and no counter logic.

Structure
REQ-031 SHALL take op_t and word_t from the shared mycpu package.
REQ-032 SHALL place opcode, funct, REGIMM-rt and COP0-rs field constants in that same shared package, for reuse by decode-side logic.
REQ-033 SHALL isolate the pure field encoding in one combinational sub-module, instr_field_pack (op and fields in; word and err out). instr_encoder holds only the handshake and buffering.

Verification
REQ-034 SHALL have a bench scenario: ADDIU rs=29 rt=29 imm=16'hFFF8, out_ready=1 -> out_instr=32'h27BDFFF8 one cycle later, out_err=0.
REQ-035 SHALL have a bench scenario: ERET, then J target=26'h0100000 back-to-back -> 32'h42000018 then 32'h08100000 on consecutive cycles.
REQ-036 SHALL have a bench scenario: DECODE_ERROR op -> out_instr=0, out_err=1; with INSTR_ENCODER_ERRCNT_EN defined, err_count goes 0->1.
REQ-037 SHALL have a bench scenario: out_ready=0 and 3 requests offered -> 2 accepted, in_ready=0, outputs stable; out_ready=1 -> both words drain in order, then the third is accepted.
REQ-038 SHALL have a bench scenario: resetn pulsed low while both entries are full -> out_valid=0, in_ready=1 immediately, and no stale word appears after release.
REQ-039 SHALL have a bench scenario: SLL rd=3 rt=2 shamt=4 with garbage in_rs/in_imm -> 32'h00021900 (unused fields zeroed).
